// File: rtl/cmd_pkt_pkg.sv
// rtl/cmd_pkt_pkg.sv - shared types and constants for the command packet wrapper
package cmd_pkt_pkg;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    localparam logic [7:0] RESP_ACK  = 8'hA5;

    // Command code range understood by the command-configuration stage
    localparam logic [7:0] CMD_FIRST = 8'h01;
    localparam logic [7:0] CMD_LAST  = 8'h08;

    function automatic logic is_known_cmd(input logic [7:0] code);
        return (code >= CMD_FIRST) && (code <= CMD_LAST);
    endfunction

endpackage

// File: rtl/resp_tx_q.sv
// rtl/resp_tx_q.sv - response transmit FSM with a 1-deep pending byte buffer
module resp_tx_q
    import cmd_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent,
    output logic       resp_drop
);

    tx_state_t  state, state_nxt;
    logic [7:0] pend, pend_nxt;
    logic       pend_vld, pend_vld_nxt;
    logic [7:0] tx_data_nxt;
    logic       trmt_nxt, sent_nxt, drop_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            pend      <= 8'h00;
            pend_vld  <= 1'b0;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            resp_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            pend_vld  <= pend_vld_nxt;
            tx_data   <= tx_data_nxt;
            trmt      <= trmt_nxt;
            resp_sent <= sent_nxt;
            resp_drop <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        tx_data_nxt  = tx_data;
        trmt_nxt     = 1'b0;
        sent_nxt     = 1'b0;
        drop_nxt     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_nxt = resp;
                    trmt_nxt    = 1'b1;
                    state_nxt   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done && pend_vld) begin
                    // Old pending goes out; a coincident request takes its slot
                    tx_data_nxt  = pend;
                    trmt_nxt     = 1'b1;
                    pend_vld_nxt = send_resp;
                    if (send_resp) pend_nxt = resp;
                end else if (tx_done) begin
                    if (send_resp) begin
                        tx_data_nxt = resp;
                        trmt_nxt    = 1'b1;
                    end else begin
                        state_nxt = TX_IDLE;
                        sent_nxt  = 1'b1;
                    end
                end else if (send_resp) begin
                    drop_nxt     = pend_vld;
                    pend_nxt     = resp;
                    pend_vld_nxt = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/cmd_pkt_wrapper.sv
// rtl/cmd_pkt_wrapper.sv - UART byte stream to 3-byte command packets, responses back out
module cmd_pkt_wrapper
    import cmd_pkt_pkg::*;
#(
    parameter int TMO_W = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        pkt_tmo,
    output logic        resp_drop
);

    rx_state_t        rx_state, rx_nxt;
    logic [7:0]       cmd_sh, hi_sh;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit, pkt_done;

    assign clr_rx_rdy = rx_rdy;

    // A byte landing on the all-ones cycle wins over the timeout
    assign tmo_hit = (rx_state != WAIT_CMD) && (&tmo_cnt) && !rx_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= WAIT_CMD;
        else        rx_state <= rx_nxt;
    end

    always_comb begin
        rx_nxt   = rx_state;
        pkt_done = 1'b0;
        case (rx_state)
            WAIT_CMD: if (rx_rdy) rx_nxt = WAIT_HI;
            WAIT_HI: begin
                if (rx_rdy)       rx_nxt = WAIT_LO;
                else if (tmo_hit) rx_nxt = WAIT_CMD;
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    rx_nxt   = WAIT_CMD;
                    pkt_done = 1'b1;
                end else if (tmo_hit) begin
                    rx_nxt = WAIT_CMD;
                end
            end
            default: rx_nxt = WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sh  <= 8'h00;
            hi_sh   <= 8'h00;
            tmo_cnt <= '0;
        end else begin
            if (rx_rdy && rx_state == WAIT_CMD) cmd_sh <= rx_data;
            if (rx_rdy && rx_state == WAIT_HI)  hi_sh  <= rx_data;
            if (rx_state == WAIT_CMD || rx_rdy || tmo_hit) tmo_cnt <= '0;
            else                                           tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Packet outputs move only on completion so downstream sees a stable packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= 8'h00;
            data    <= 16'h0000;
            cmd_rdy <= 1'b0;
            pkt_tmo <= 1'b0;
        end else begin
            pkt_tmo <= tmo_hit;
            if (pkt_done) begin
                cmd     <= cmd_sh;
                data    <= {hi_sh, rx_data};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    resp_tx_q u_resp_tx_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent),
        .resp_drop (resp_drop)
    );

endmodule

// File: tb/tb_cmd_pkt_wrapper.sv
// tb/tb_cmd_pkt_wrapper.sv - scoreboard bench for cmd_pkt_wrapper
module tb_cmd_pkt_wrapper;
    import cmd_pkt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        resp_sent;
    logic        pkt_tmo;
    logic        resp_drop;

    int n_chk = 0;
    int n_fail = 0;
    int n_clr_rx = 0;
    int n_tmo = 0;
    int n_sent = 0;
    int n_drop = 0;

    logic [23:0] q_pkt[$];
    logic [7:0]  q_tx[$];
    logic [23:0] prev_pkt = 24'h0;
    logic        prev_rdy = 1'b0;
    logic        prev_trmt = 1'b0;

    cmd_pkt_wrapper #(.TMO_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .pkt_tmo     (pkt_tmo),
        .resp_drop   (resp_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pulse counters plus scoreboard pops for packets and transmitted bytes
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pkt  <= {cmd, data};
            prev_rdy  <= cmd_rdy;
            prev_trmt <= 1'b0;
        end else begin
            if (clr_rx_rdy) n_clr_rx <= n_clr_rx + 1;
            if (pkt_tmo)    n_tmo    <= n_tmo + 1;
            if (resp_sent)  n_sent   <= n_sent + 1;
            if (resp_drop)  n_drop   <= n_drop + 1;
            if (trmt) begin
                chk("trmt_width", prev_trmt, 0);
                if (q_tx.size() == 0) chk("tx_unexpected", trmt, 0);
                else                  chk("tx_data", tx_data, q_tx.pop_front());
            end
            if ((cmd_rdy && !prev_rdy) || ({cmd, data} != prev_pkt)) begin
                if (q_pkt.size() == 0) chk("pkt_unexpected", q_pkt.size(), 1);
                else                   chk("pkt", {cmd, data}, q_pkt.pop_front());
            end
            prev_pkt  <= {cmd, data};
            prev_rdy  <= cmd_rdy;
            prev_trmt <= trmt;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(posedge clk); #1;
        rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = clr;
        @(posedge clk); #1;
        rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    endtask

    task automatic tx_evt(input logic s, input logic [7:0] r, input logic d);
        @(posedge clk); #1;
        send_resp = s; resp = r; tx_done = d;
        @(posedge clk); #1;
        send_resp = 1'b0; tx_done = 1'b0;
    endtask

    task automatic clear_cmd();
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t0, s0, d0, lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx", {cmd_rdy, cmd, data, pkt_tmo}, 0);
        chk("rst_tx", {trmt, tx_data, resp_sent, resp_drop}, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic packet with gaps
        c0 = n_clr_rx;
        q_pkt.push_back(24'h021234);
        send_byte(8'h02, 1'b0); idle(3);
        send_byte(8'h12, 1'b0); idle(3);
        send_byte(8'h34, 1'b0);
        chk("cmd_rdy_lat", cmd_rdy, 1);
        idle(3);
        chk("clr_rx_pulses", n_clr_rx - c0, 3);
        clear_cmd();
        chk("cmd_rdy_clr", cmd_rdy, 0);

        // Partial packet timeout
        t0 = n_tmo;
        send_byte(8'h05, 1'b0); idle(2);
        send_byte(8'h00, 1'b0);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (pkt_tmo) begin
                lat = i;
                break;
            end
        end
        chk("tmo_latency_ok", (lat >= 63 && lat <= 64), 1);
        idle(2);
        chk("tmo_once", n_tmo - t0, 1);
        chk("tmo_keep", {cmd, data}, 24'h021234);
        chk("tmo_rdy", cmd_rdy, 0);
        q_pkt.push_back(24'h04FFFE);
        send_byte(8'h04, 1'b0); idle(1);
        send_byte(8'hFF, 1'b0); idle(1);
        send_byte(8'hFE, 1'b0);
        chk("resync_rdy", cmd_rdy, 1);

        // Packet B completes while A is held and clear coincides
        send_byte(8'h03, 1'b0); idle(2);
        chk("hold_a1", {cmd, data}, 24'h04FFFE);
        send_byte(8'hAA, 1'b0); idle(2);
        chk("hold_a2", {cmd, data}, 24'h04FFFE);
        q_pkt.push_back(24'h03AA55);
        send_byte(8'h55, 1'b1);
        chk("set_wins", cmd_rdy, 1);
        idle(2);
        clear_cmd();

        // Single ACK response
        q_tx.push_back(RESP_ACK);
        tx_evt(1'b1, RESP_ACK, 1'b0);
        chk("trmt_lat", trmt, 1);
        s0 = n_sent;
        idle(20);
        tx_evt(1'b0, 8'h00, 1'b1);
        chk("resp_sent_pulse", resp_sent, 1);
        idle(2);
        chk("resp_sent_cnt", n_sent - s0, 1);

        // Pending overwrite, then coincident done and request
        d0 = n_drop;
        q_tx.push_back(8'h40);
        tx_evt(1'b1, 8'h40, 1'b0);
        chk("idle_launch", trmt, 1);
        tx_evt(1'b1, 8'h7C, 1'b0);
        tx_evt(1'b1, 8'h3B, 1'b0);
        idle(1);
        chk("drop_cnt", n_drop - d0, 1);
        q_tx.push_back(8'h3B);
        tx_evt(1'b0, 8'h00, 1'b1);
        chk("relaunch", trmt, 1);
        tx_evt(1'b1, 8'h22, 1'b0);
        q_tx.push_back(8'h22);
        q_tx.push_back(8'h11);
        tx_evt(1'b1, 8'h11, 1'b1);
        chk("coinc_launch", trmt, 1);
        idle(2);
        chk("coinc_no_drop", n_drop - d0, 1);
        tx_evt(1'b0, 8'h00, 1'b1);
        chk("pend_launch", trmt, 1);
        s0 = n_sent;
        tx_evt(1'b0, 8'h00, 1'b1);
        idle(1);
        chk("final_sent", n_sent - s0, 1);
        chk("tx_q_drained", q_tx.size(), 0);

        // Reset mid-packet and mid-transmit with a pending byte
        send_byte(8'h06, 1'b0);
        q_tx.push_back(8'h50);
        tx_evt(1'b1, 8'h50, 1'b0);
        tx_evt(1'b1, 8'h60, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx", {cmd_rdy, cmd, data, pkt_tmo}, 0);
        chk("mid_rst_tx", {trmt, tx_data, resp_sent, resp_drop}, 0);
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("no_stale_trmt", trmt, 0);
        end
        s0 = n_sent;
        tx_evt(1'b0, 8'h00, 1'b1);
        idle(2);
        chk("idle_done_ignored", n_sent - s0, 0);
        q_pkt.push_back(24'h070102);
        send_byte(8'h07, 1'b0); idle(1);
        send_byte(8'h01, 1'b0); idle(1);
        send_byte(8'h02, 1'b0);
        chk("post_rst_rdy", cmd_rdy, 1);
        idle(5);
        chk("pkt_q_drained", q_pkt.size(), 0);
        chk("tx_q_empty", q_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
